// File: rtl/vram_console_ctrl.sv
// Text-console write sequencer for a COLS x ROWS character video RAM: cursor, control codes, clear and scroll.
// Optional macro VRAM_CTRL_SCROLL_EN: a bottom-row newline scrolls (COPY + CLR_LINE) instead of wrapping to row 0.
module vram_console_ctrl #(
    parameter int COLS   = 100,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] w_addr,
    output logic [7:0]        w_data,
    output logic              w_en,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [7:0]        r_data,
    output logic [6:0]        cur_col,
    output logic [4:0]        cur_row,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_CLR_ALL  = 2'd0;
    localparam logic [1:0] S_IDLE     = 2'd1;
    localparam logic [1:0] S_COPY     = 2'd2;
    localparam logic [1:0] S_CLR_LINE = 2'd3;

    localparam logic [ADDR_W-1:0] A_ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_COLS     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] A_LAST     = ADDR_W'(COLS*ROWS-1);
    localparam logic [ADDR_W-1:0] A_LINE_OFS = ADDR_W'(COLS-1);
    localparam logic [6:0]        LAST_COL   = 7'(COLS-1);
    localparam logic [4:0]        LAST_ROW   = 5'(ROWS-1);
    localparam logic [7:0]        SPACE      = 8'h20;

    logic [1:0]        state_q, state_d;
    logic [6:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              rdy_q, rdy_d;
    logic              newline;

    // A byte transfers on a rising edge where in_valid && in_ready; in_ready is a
    // registered copy of (state == IDLE) and never looks at in_valid.
    wire xfer = in_valid && rdy_q;

`ifdef VRAM_CTRL_SCROLL_EN
    localparam logic [ADDR_W-1:0] A_LAST_BASE = ADDR_W'(COLS*(ROWS-1));
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              rd_pend_q, rd_pend_d;
    logic              dat_pend_q, dat_pend_d;

    // rd_pend: r_addr holds a live read this cycle; dat_pend: r_data is valid this cycle.
    always_comb begin
        raddr_d    = raddr_q;
        rd_pend_d  = 1'b0;
        dat_pend_d = 1'b0;
        if (state_q == S_IDLE && state_d == S_COPY) begin
            raddr_d   = A_COLS;
            rd_pend_d = 1'b1;
        end else if (state_q == S_COPY) begin
            dat_pend_d = rd_pend_q;
            if (rd_pend_q && raddr_q != A_LAST) begin
                raddr_d   = raddr_q + A_ONE;
                rd_pend_d = 1'b1;
            end
        end
    end

    assign r_addr = raddr_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^r_data;
    assign r_addr = '0;
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        newline = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        wen_d   = 1'b1;
                        waddr_d = base_q + ADDR_W'(col_q);
                        wdata_d = in_data;
                        if (col_q == LAST_COL) newline = 1'b1;
                        else                   col_d   = col_q + 7'd1;
                    end else begin
                        case (in_data)
                            8'h0A: newline = 1'b1;
                            8'h0D: col_d = 7'd0;
                            8'h08: begin
                                if (col_q != 7'd0) begin
                                    col_d   = col_q - 7'd1;
                                    wen_d   = 1'b1;
                                    waddr_d = base_q + ADDR_W'(col_q - 7'd1);
                                    wdata_d = SPACE;
                                end
                            end
                            8'h0C: begin
                                state_d = S_CLR_ALL;
                                col_d   = 7'd0;
                                row_d   = 5'd0;
                                base_d  = '0;
                                cnt_d   = '0;
                            end
                            default: ;
                        endcase
                    end
                    if (newline) begin
                        col_d = 7'd0;
                        if (row_q != LAST_ROW) begin
                            row_d  = row_q + 5'd1;
                            base_d = base_q + A_COLS;
                        end else begin
`ifdef VRAM_CTRL_SCROLL_EN
                            state_d = S_COPY;
                            cnt_d   = '0;
`else
                            state_d = S_CLR_LINE;
                            row_d   = 5'd0;
                            base_d  = '0;
                            cnt_d   = '0;
`endif
                        end
                    end
                end
            end
            S_CLR_ALL: begin
                wen_d   = 1'b1;
                waddr_d = cnt_q;
                wdata_d = SPACE;
                cnt_d   = cnt_q + A_ONE;
                if (cnt_q == A_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_CLR_LINE: begin
                wen_d   = 1'b1;
                waddr_d = cnt_q;
                wdata_d = SPACE;
                cnt_d   = cnt_q + A_ONE;
                if (cnt_q == base_q + A_LINE_OFS) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
`ifdef VRAM_CTRL_SCROLL_EN
            S_COPY: begin
                // Each returned byte lands one row above the address it was read from.
                if (dat_pend_q) begin
                    wen_d   = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = r_data;
                    cnt_d   = cnt_q + A_ONE;
                    if (cnt_q == A_LAST_BASE - A_ONE) begin
                        state_d = S_CLR_LINE;
                        cnt_d   = A_LAST_BASE;
                    end
                end
            end
`endif
            default: state_d = S_CLR_ALL;
        endcase
        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_CLR_ALL;
            col_q   <= 7'd0;
            row_q   <= 5'd0;
            base_q  <= '0;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'h00;
            rdy_q   <= 1'b0;
`ifdef VRAM_CTRL_SCROLL_EN
            raddr_q    <= '0;
            rd_pend_q  <= 1'b0;
            dat_pend_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rdy_q   <= rdy_d;
`ifdef VRAM_CTRL_SCROLL_EN
            raddr_q    <= raddr_d;
            rd_pend_q  <= rd_pend_d;
            dat_pend_q <= dat_pend_d;
`endif
        end
    end

    assign w_en      = wen_q;
    assign w_addr    = waddr_q;
    assign w_data    = wdata_q;
    assign in_ready  = rdy_q;
    assign busy      = ~rdy_q;
    assign cur_col   = col_q;
    assign cur_row   = row_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vram_console_ctrl.sv
// Directed bench for vram_console_ctrl: a RAM model plus an expected-write queue checked on every w_en.
// Expectations follow VRAM_CTRL_SCROLL_EN when the bench is built with the macro defined.
module tb_vram_console_ctrl;
    localparam int COLS   = 100;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 12;
    localparam int BOUND  = 10000;

    logic              clk;
    logic              rst_n;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_data;
    logic              w_en;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic [6:0]        cur_col;
    logic [4:0]        cur_row;
    logic              busy;
    logic [1:0]        dbg_state;

    vram_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .w_addr(w_addr), .w_data(w_data), .w_en(w_en), .r_addr(r_addr), .r_data(r_data),
        .cur_col(cur_col), .cur_row(cur_row), .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // video RAM model with a bench-only preload port
    logic [7:0]        mem [0:4095];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [7:0]        pl_data;
    always @(posedge clk) begin
        if (pl_en)     mem[pl_addr] <= pl_data;
        else if (w_en) mem[w_addr]  <= w_data;
        r_data <= mem[r_addr];
    end

    // scoreboard
    logic [19:0] exp_q[$];
    logic [7:0]  exp_mem [0:4095];
    int n_cmp = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int last_wr_cyc = 0;
    int prev_wr_cyc = 0;
    int m_col = 0;
    int m_row = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (w_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL unexpected_write: observed addr=%0d data=%0h expected no write", w_addr, w_data);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                check("write_addr_data", {w_addr, w_data}, 32'(e));
            end
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
            wr_cnt++;
        end
    end

    task automatic push_wr(input int a, input logic [7:0] d);
        exp_q.push_back({12'(a), d});
        exp_mem[a] = d;
    endtask

    task automatic push_clear_all();
        for (int a = 0; a < COLS*ROWS; a++) push_wr(a, 8'h20);
    endtask

    task automatic model_newline();
        m_col = 0;
        if (m_row < ROWS-1) m_row++;
        else begin
`ifdef VRAM_CTRL_SCROLL_EN
            for (int a = 0; a < COLS*(ROWS-1); a++) push_wr(a, exp_mem[a+COLS]);
            for (int c = 0; c < COLS; c++) push_wr(COLS*(ROWS-1)+c, 8'h20);
`else
            m_row = 0;
            for (int c = 0; c < COLS; c++) push_wr(c, 8'h20);
`endif
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_wr(m_row*COLS + m_col, b);
            if (m_col == COLS-1) model_newline();
            else m_col++;
        end else if (b == 8'h0A) model_newline();
        else if (b == 8'h0D) m_col = 0;
        else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_wr(m_row*COLS + m_col, 8'h20);
            end
        end else if (b == 8'h0C) begin
            m_col = 0;
            m_row = 0;
            push_clear_all();
        end
    endtask

    // driver tasks: all start and end on a falling edge
    task automatic send(input logic [7:0] b);
        int n = 0;
        while (in_ready !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) check("ready_timeout", in_ready, 1);
        in_data  = b;
        in_valid = 1'b1;
        model_byte(b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int lowcnt);
        lowcnt = 0;
        while (in_ready !== 1'b1 && lowcnt < BOUND) begin
            lowcnt++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic preload_row(input int r, input logic [7:0] v);
        for (int c = 0; c < COLS; c++) begin
            pl_en   = 1'b1;
            pl_addr = 12'(r*COLS + c);
            pl_data = v;
            exp_mem[r*COLS + c] = v;
            @(negedge clk);
        end
        pl_en = 1'b0;
    endtask

    task automatic check_row(input string tag, input int r, input logic [7:0] v);
        int bad = 0;
        for (int c = 0; c < COLS; c++) if (mem[r*COLS + c] !== v) bad++;
        check(tag, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        int wr0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        pl_en = 1'b0; pl_addr = '0; pl_data = 8'h00;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_w_en", w_en, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_w_data", w_data, 0);
        check("rst_r_addr", r_addr, 0);
        check("rst_cur_col", cur_col, 0);
        check("rst_cur_row", cur_row, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 1);

        // power-up clear
        push_clear_all();
        rst_n = 1'b1;
        wait_idle(low);
        check("clr_all_low_cycles", low, 3000);
        check("clr_all_drained", exp_q.size(), 0);
        check("home_col", cur_col, 0);
        check("home_row", cur_row, 0);
        check("busy_mirror", busy, 0);

        // "AB" back-to-back
        send(8'h41);
        send(8'h42);
        @(negedge clk);
        check("ab_consecutive", last_wr_cyc - prev_wr_cyc, 1);
        check("ab_col", cur_col, 2);

        // line wrap at the last column
        send(8'h0D);
        for (int i = 0; i < 99; i++) send(8'h78);
        send(8'h79);
        check("wrap_row", cur_row, 1);
        check("wrap_col", cur_col, 0);
        send(8'h7A);
        @(negedge clk);
        check("z_col", cur_col, 1);
        check("wrap_drained", exp_q.size(), 0);

        // backspace, including the no-op at column 0
        send(8'h0D);
        wr0 = wr_cnt;
        send(8'h51);
        send(8'h08);
        send(8'h08);
        repeat (2) @(negedge clk);
        check("bs_write_count", wr_cnt - wr0, 2);
        check("bs_col", cur_col, 0);

        // bottom-row newline
        while (m_row != ROWS-1) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h6B);
        @(negedge clk);
        check("pre_scroll_row", cur_row, 29);
        check("pre_scroll_col", cur_col, 5);
        preload_row(1, 8'h31);
        preload_row(29, 8'h39);
        send(8'h0A);
        check("scroll_busy", busy, 1);
        wait_idle(low);
`ifdef VRAM_CTRL_SCROLL_EN
        check("scroll_low_cycles", low, 2900 + 1 + 100);
        check("scroll_row", cur_row, 29);
        check_row("scroll_row0", 0, 8'h31);
        check_row("scroll_row28", 28, 8'h39);
        check_row("scroll_row29", 29, 8'h20);
`else
        check("wrap_low_cycles", low, 100);
        check("wrap0_row", cur_row, 0);
        check_row("wrap_row0", 0, 8'h20);
        check_row("wrap_row1", 1, 8'h31);
        check_row("wrap_row29", 29, 8'h39);
`endif
        check("scroll_col", cur_col, 0);
        check("scroll_drained", exp_q.size(), 0);

        // form feed
        send(8'h4D);
        send(8'h0C);
        wait_idle(low);
        check("ff_low_cycles", low, 3000);
        check("ff_col", cur_col, 0);
        check("ff_row", cur_row, 0);
        check("ff_drained", exp_q.size(), 0);

        // reset in the middle of a multi-cycle bottom-row operation
        while (m_row != ROWS-1) send(8'h0A);
        send(8'h0A);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        check("rst_edge_w_en", w_en, 0);
        @(negedge clk);
        check("rst_next_w_en", w_en, 0);
        check("rst_mid_in_ready", in_ready, 0);
        m_col = 0;
        m_row = 0;
        push_clear_all();
        rst_n = 1'b1;
        wait_idle(low);
        check("rst_clr_low_cycles", low, 3000);
        check("rst_clr_drained", exp_q.size(), 0);
        check("rst_home_col", cur_col, 0);
        check("rst_home_row", cur_row, 0);
        check_row("rst_row29", 29, 8'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
